// File: rtl/harp_scan_scheduler.sv
// Laser-harp measurement scheduler: steps the mirror, gates the laser, runs a dark and a lit
// ADC conversion per position and writes the saturated lit-minus-dark value to the string file.
module harp_scan_scheduler #(
  parameter int NUM_POS       = 8,
  parameter int STEPS_PER_POS = 2,
  parameter int STEP_TICKS    = 98304,
  parameter int SETTLE_TICKS  = 4096,
  parameter int ADC_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [3:0] step_phase,
  output logic [2:0] cur_pos,
  output logic       laser_on,
  output logic       adc_start,
  input  logic       adc_ready,
  input  logic [9:0] adc_data,
  output logic       str_wr,
  output logic [2:0] str_idx,
  output logic [7:0] str_val,
  output logic       scan_done,
  output logic       adc_err
);

  typedef enum logic [3:0] {
    IDLE, STEP, SETTLE, DARK_REQ, DARK_WAIT, LIT_SETTLE, LIT_REQ, LIT_WAIT, WRITE, ADVANCE
  } state_t;

  localparam int TMAX = (STEP_TICKS > SETTLE_TICKS) ? STEP_TICKS : SETTLE_TICKS;
  localparam int TW = $clog2(TMAX + 1);
  localparam int SW = $clog2(STEPS_PER_POS + 1);
  localparam logic [2:0] LAST_POS = 3'(NUM_POS - 1);

  state_t state, state_next;
  logic [TW-1:0] tick;
  logic [SW-1:0] step_cnt;
  logic [11:0]   adc_cnt;
  logic          seen_low, dir_rev, need_step;
  logic [9:0]    dark;

  logic step_tick_done, last_step, settle_done, conv_done, in_wait, timeout;
  logic laser_d, adc_start_d, str_wr_d, scan_done_d, adc_err_d;
  logic [2:0] str_idx_d;
  logic [7:0] str_val_d, val_s;

  assign step_tick_done = (tick == TW'(STEP_TICKS - 1));
  assign last_step      = (step_cnt == SW'(STEPS_PER_POS - 1));
  assign settle_done    = (tick >= TW'(SETTLE_TICKS - 1));
  assign conv_done      = seen_low && adc_ready;
  assign in_wait        = (state == DARK_WAIT) || (state == LIT_WAIT);
  // A conversion is abandoned if ready never drops early on, or never comes back at all.
  assign timeout = in_wait && ((!seen_low && adc_ready && (adc_cnt >= 12'd7)) ||
                               (!conv_done && (int'(adc_cnt) >= ADC_TIMEOUT - 1)));
  assign val_s = (adc_data > dark) ? 8'((adc_data - dark) >> 2) : 8'd0;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (enable && adc_ready) state_next = need_step ? STEP : SETTLE;
                  else state_next = IDLE;
      STEP:       if (step_tick_done && last_step) state_next = SETTLE;
                  else state_next = STEP;
      SETTLE:     if (settle_done && adc_ready) state_next = DARK_REQ;
                  else state_next = SETTLE;
      DARK_REQ:   state_next = DARK_WAIT;
      DARK_WAIT:  if (timeout) state_next = ADVANCE;
                  else if (conv_done) state_next = LIT_SETTLE;
                  else state_next = DARK_WAIT;
      LIT_SETTLE: if (settle_done && adc_ready) state_next = LIT_REQ;
                  else state_next = LIT_SETTLE;
      LIT_REQ:    state_next = LIT_WAIT;
      LIT_WAIT:   if (timeout) state_next = ADVANCE;
                  else if (conv_done) state_next = WRITE;
                  else state_next = LIT_WAIT;
      WRITE:      state_next = ADVANCE;
      ADVANCE:    if (enable) state_next = STEP;
                  else state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // mirror position, stepper phase, timers and dark capture
  always_ff @(posedge clk) begin
    if (reset) begin
      tick       <= '0;
      step_cnt   <= '0;
      adc_cnt    <= 12'd0;
      seen_low   <= 1'b0;
      dir_rev    <= 1'b0;
      need_step  <= 1'b0;
      dark       <= 10'd0;
      step_phase <= 4'b0001;
      cur_pos    <= 3'd0;
    end else begin
      if (state_next != state) tick <= '0;
      else if (state == STEP) tick <= step_tick_done ? '0 : tick + 1'b1;
      else if ((state == SETTLE || state == LIT_SETTLE) && !settle_done) tick <= tick + 1'b1;
      else tick <= tick;

      if (state == STEP && step_tick_done) begin
        step_cnt   <= last_step ? '0 : step_cnt + 1'b1;
        step_phase <= dir_rev ? {step_phase[0], step_phase[3:1]} : {step_phase[2:0], step_phase[3]};
      end else if (state != STEP) begin
        step_cnt <= '0;
      end else begin
        step_cnt <= step_cnt;
      end

      if (state == DARK_REQ || state == LIT_REQ) begin
        adc_cnt  <= 12'd0;
        seen_low <= 1'b0;
      end else if (in_wait) begin
        adc_cnt <= adc_cnt + 12'd1;
        if (!adc_ready) seen_low <= 1'b1;
        else seen_low <= seen_low;
      end else begin
        adc_cnt <= adc_cnt;
      end

      if (state == DARK_WAIT && conv_done) dark <= adc_data;
      else dark <= dark;

      // Position moves here; the physical step follows in STEP, even after a pause in IDLE.
      if (state == ADVANCE) begin
        need_step <= 1'b1;
        if (!dir_rev) begin
          if (cur_pos == LAST_POS) begin
            dir_rev <= 1'b1;
            cur_pos <= cur_pos - 3'd1;
          end else begin
            cur_pos <= cur_pos + 3'd1;
          end
        end else begin
          if (cur_pos == 3'd0) begin
            dir_rev <= 1'b0;
            cur_pos <= 3'd1;
          end else begin
            cur_pos <= cur_pos - 3'd1;
          end
        end
      end else if (state == STEP) begin
        need_step <= 1'b0;
      end else begin
        need_step <= need_step;
      end
    end
  end

  // output decode from the upcoming state
  always_comb begin
    laser_d     = (state_next == LIT_SETTLE) || (state_next == LIT_REQ) || (state_next == LIT_WAIT);
    adc_start_d = (state_next == DARK_REQ) || (state_next == LIT_REQ);
    str_wr_d    = (state_next == WRITE);
    str_idx_d   = str_wr_d ? cur_pos : str_idx;
    str_val_d   = str_wr_d ? val_s : str_val;
    scan_done_d = str_wr_d && ((cur_pos == 3'd0) || (cur_pos == LAST_POS));
    adc_err_d   = adc_err | timeout;
  end

  // output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      laser_on  <= 1'b0;
      adc_start <= 1'b0;
      str_wr    <= 1'b0;
      str_idx   <= 3'd0;
      str_val   <= 8'd0;
      scan_done <= 1'b0;
      adc_err   <= 1'b0;
    end else begin
      laser_on  <= laser_d;
      adc_start <= adc_start_d;
      str_wr    <= str_wr_d;
      str_idx   <= str_idx_d;
      str_val   <= str_val_d;
      scan_done <= scan_done_d;
      adc_err   <= adc_err_d;
    end
  end

endmodule

// File: tb/tb_harp_scan_scheduler.sv
// Scoreboard bench for harp_scan_scheduler: expected string writes are queued by the stimulus
// and popped by a write monitor; a behavioural ADC reader answers adc_start requests.
module tb_harp_scan_scheduler;

  logic       clk = 1'b0;
  logic       reset, enable, adc_ready;
  logic [9:0] adc_data;
  logic [3:0] step_phase;
  logic [2:0] cur_pos, str_idx;
  logic [7:0] str_val;
  logic       laser_on, adc_start, str_wr, scan_done, adc_err;

  harp_scan_scheduler #(
    .NUM_POS(8), .STEPS_PER_POS(2), .STEP_TICKS(16), .SETTLE_TICKS(8), .ADC_TIMEOUT(64)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .step_phase(step_phase), .cur_pos(cur_pos),
    .laser_on(laser_on), .adc_start(adc_start), .adc_ready(adc_ready), .adc_data(adc_data),
    .str_wr(str_wr), .str_idx(str_idx), .str_val(str_val), .scan_done(scan_done), .adc_err(adc_err)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int val; int done; } exp_t;
  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  int wr_count = 0;
  int n_steps = 0;
  int dark_v = 100;
  int lit_v = 612;
  logic adc_dead = 1'b0;
  logic phase_chk = 1'b0;
  logic prev_ready = 1'b1;
  logic [3:0] prev_phase = 4'b0001;
  logic [3:0] m_phase = 4'b0001;
  int exp_seq [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input int v, input int d);
    exp_t e;
    e.idx = i; e.val = v; e.done = d;
    q.push_back(e);
  endtask

  task automatic wait_writes(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (wr_count >= n) return;
    end
    chk("write_wait_timeout", wr_count, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_step_phase"}, step_phase, 1);
    chk({tag, "_cur_pos"}, cur_pos, 0);
    chk({tag, "_laser_on"}, laser_on, 0);
    chk({tag, "_adc_start"}, adc_start, 0);
    chk({tag, "_str_wr"}, str_wr, 0);
    chk({tag, "_scan_done"}, scan_done, 0);
    chk({tag, "_adc_err"}, adc_err, 0);
    chk({tag, "_str_idx"}, str_idx, 0);
    chk({tag, "_str_val"}, str_val, 0);
  endtask

  // behavioural ADC reader: ready drops after a request, result appears three cycles later
  initial begin
    logic [9:0] d;
    adc_ready = 1'b1;
    adc_data  = 10'd0;
    forever begin
      @(negedge clk);
      if (adc_start && !adc_dead) begin
        d = laser_on ? 10'(lit_v) : 10'(dark_v);
        adc_ready = 1'b0;
        repeat (3) @(negedge clk);
        adc_data  = d;
        adc_ready = 1'b1;
      end
    end
  end

  // write monitor / scoreboard
  always @(negedge clk) begin
    if (str_wr) begin
      chk("laser_off_at_write", laser_on, 0);
      if (q.size() == 0) begin
        chk("unexpected_write", str_wr, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("str_idx", str_idx, e.idx);
        chk("str_val", str_val, e.val);
        chk("scan_done", scan_done, e.done);
      end
      wr_count <= wr_count + 1;
    end else if (scan_done) begin
      chk("scan_done_without_write", scan_done, 0);
    end
    if (adc_start) chk("start_after_ready", prev_ready, 1);
    prev_ready <= adc_ready;
  end

  // stepper monitor against the expected sweep order
  always @(negedge clk) begin
    int mi;
    logic [3:0] exp_p;
    if (phase_chk && step_phase != prev_phase) begin
      mi = n_steps / 2;
      if (mi < 15) begin
        exp_p = (exp_seq[mi + 1] > exp_seq[mi]) ? {m_phase[2:0], m_phase[3]}
                                                 : {m_phase[0], m_phase[3:1]};
        chk("step_phase", step_phase, exp_p);
        m_phase <= exp_p;
      end else begin
        chk("extra_step", n_steps, 29);
      end
      n_steps <= n_steps + 1;
    end
    prev_phase <= step_phase;
  end

  initial begin
    int base;
    reset = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // full ping-pong sweep, dark=100 lit=612 -> 128
    for (int i = 0; i < 16; i++) push(exp_seq[i], 128, (exp_seq[i] == 0 || exp_seq[i] == 7) ? 1 : 0);
    phase_chk = 1'b1;
    enable = 1'b1;
    wait_writes(16, 3000);
    enable = 1'b0;
    repeat (40) @(negedge clk);
    phase_chk = 1'b0;
    chk("phase_advances", n_steps, 30);

    // lit below dark floors to zero, then full-scale
    dark_v = 700; lit_v = 300;
    push(2, 0, 0);
    enable = 1'b1;
    wait_writes(17, 400);
    dark_v = 0; lit_v = 1023;
    push(3, 255, 0);
    // drop enable in the middle of the lit conversion at position 3
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (cur_pos == 3'd3 && laser_on && !adc_ready) break;
    end
    enable = 1'b0;
    wait_writes(18, 100);
    repeat (60) @(negedge clk);
    chk("idle_laser_off", laser_on, 0);
    chk("idle_no_more_writes", wr_count, 18);
    dark_v = 100; lit_v = 612;
    push(4, 128, 0);
    enable = 1'b1;
    wait_writes(19, 400);

    // dead ADC at position 5: timeout, no write, scan continues
    adc_dead = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (adc_err) break;
    end
    chk("adc_err_set", adc_err, 1);
    chk("timeout_laser_off", laser_on, 0);
    adc_dead = 1'b0;
    dark_v = 5; lit_v = 1000;
    push(6, 248, 0);
    wait_writes(20, 400);
    dark_v = 512; lit_v = 512;
    push(7, 0, 1);
    wait_writes(21, 400);
    chk("adc_err_sticky", adc_err, 1);

    // reset while waiting on the dark conversion
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (adc_start) break;
    end
    chk("dark_start_seen", adc_start, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midconv_reset");
    reset = 1'b0;
    base = wr_count;
    repeat (40) @(negedge clk);
    chk("late_ready_no_write", wr_count, base);
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
